// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a one-cycle-latency synchronous ROM.
// Out-of-range reads complete with an error flag without touching the ROM.
module rom_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [31:0]       addr0,
    input  logic              req1,
    input  logic [31:0]       addr1,
    output logic              ack0,
    output logic [DWIDTH-1:0] data0,
    output logic              err0,
    output logic              ack1,
    output logic [DWIDTH-1:0] data1,
    output logic              err1,
    output logic              rom_rd,
    output logic [31:0]       rom_addr,
    input  logic [DWIDTH-1:0] rom_data,
    output logic [15:0]       stall_cnt
);

    logic        inflight_q, inflight_d;
    logic        owner_q, owner_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        elig0, elig1;
    logic        grant, grant_port, in_range;
    logic [31:0] grant_addr;

    always_comb begin
        ack0  = inflight_q && !owner_q;
        ack1  = inflight_q && owner_q;
        err0  = ack0 && err_q;
        err1  = ack1 && err_q;
        data0 = (ack0 && !err_q) ? rom_data : '0;
        data1 = (ack1 && !err_q) ? rom_data : '0;
    end

    // A port whose read completes this cycle is not eligible, so a tie always
    // means neither port is in flight and the pointer picks the other port.
    always_comb begin
        elig0      = req0 && !ack0;
        elig1      = req1 && !ack1;
        grant      = elig0 || elig1;
        grant_port = (elig0 && elig1) ? !last_q : elig1;
        grant_addr = grant_port ? addr1 : addr0;
        in_range   = (grant_addr >> DEPTH_LOG2) == 32'd0;
        rom_rd     = grant && in_range && !reset;
        rom_addr   = rom_rd ? grant_addr : 32'd0;
    end

    always_comb begin
        inflight_d  = grant;
        owner_d     = grant_port;
        err_d       = grant && !in_range;
        last_d      = grant ? grant_port : last_q;
        stall_cnt_d = stall_cnt_q;
        if (elig0 && elig1 && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            owner_q     <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 1'b1;
            stall_cnt_q <= 16'd0;
        end else begin
            inflight_q  <= inflight_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
            last_q      <= last_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed request sequences, a transaction-level model
// checked every falling edge, and literal expectations for key cycles.
module tb_rom_arbiter;

    localparam int DWIDTH     = 32;
    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 8;

    logic              clock;
    logic              reset;
    logic              req0, req1;
    logic [31:0]       addr0, addr1;
    logic              ack0, ack1;
    logic [DWIDTH-1:0] data0, data1;
    logic              err0, err1;
    logic              rom_rd;
    logic [31:0]       rom_addr;
    logic [DWIDTH-1:0] rom_data;
    logic [15:0]       stall_cnt;

    logic [DWIDTH-1:0] rom_mem [DEPTH];

    int tests;
    int fails;
    int lit_id;
    int preload_tag;
    int preload_seen;
    bit forced;

    // Transaction-level model state: the read in flight, who won last, stalls.
    bit          m_valid;
    int          m_owner;
    bit          m_err;
    logic [31:0] m_addr;
    int          m_last;
    int          m_stall;

    rom_arbiter #(.DWIDTH(DWIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .addr0     (addr0),
        .req1      (req1),
        .addr1     (addr1),
        .ack0      (ack0),
        .data0     (data0),
        .err0      (err0),
        .ack1      (ack1),
        .data1     (data1),
        .err1      (err1),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        rom_mem[0] = 32'h0BAD_F00D;
        rom_mem[1] = 32'h1111_1111;
        rom_mem[2] = 32'h2222_2222;
        rom_mem[3] = 32'hDEAD_BEEF;
        rom_mem[4] = 32'h4444_4444;
        rom_mem[5] = 32'h5555_5555;
        rom_mem[6] = 32'h6666_6666;
        rom_mem[7] = 32'h7777_7777;
    end

    always @(posedge clock) begin
        if (rom_rd) begin
            rom_data <= rom_mem[rom_addr[DEPTH_LOG2-1:0]];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare process: model check, literal pins, and stall counter preload.
    always @(negedge clock) begin
        bit          x_ack0, x_ack1, e0, e1, granted, inr;
        int          gport;
        logic [31:0] gaddr, x_data0, x_data1;
        if (reset) begin
            check_output("rst ack0", {31'd0, ack0}, 32'd0);
            check_output("rst ack1", {31'd0, ack1}, 32'd0);
            check_output("rst data0", data0, 32'd0);
            check_output("rst data1", data1, 32'd0);
            check_output("rst err0", {31'd0, err0}, 32'd0);
            check_output("rst err1", {31'd0, err1}, 32'd0);
            check_output("rst rom_rd", {31'd0, rom_rd}, 32'd0);
            check_output("rst rom_addr", rom_addr, 32'd0);
            check_output("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
            m_valid = 1'b0;
            m_last  = 1;
            m_stall = 0;
        end else begin
            x_ack0  = m_valid && m_owner == 0;
            x_ack1  = m_valid && m_owner == 1;
            x_data0 = (x_ack0 && !m_err) ? rom_mem[m_addr[DEPTH_LOG2-1:0]] : 32'd0;
            x_data1 = (x_ack1 && !m_err) ? rom_mem[m_addr[DEPTH_LOG2-1:0]] : 32'd0;
            e0      = req0 && !x_ack0;
            e1      = req1 && !x_ack1;
            granted = e0 || e1;
            if (e0 && e1) gport = (m_last == 0) ? 1 : 0;
            else          gport = e1 ? 1 : 0;
            gaddr   = (gport == 1) ? addr1 : addr0;
            inr     = gaddr < DEPTH;
            check_output("ack0", {31'd0, ack0}, {31'd0, x_ack0});
            check_output("ack1", {31'd0, ack1}, {31'd0, x_ack1});
            check_output("data0", data0, x_data0);
            check_output("data1", data1, x_data1);
            check_output("err0", {31'd0, err0}, {31'd0, x_ack0 && m_err});
            check_output("err1", {31'd0, err1}, {31'd0, x_ack1 && m_err});
            check_output("rom_rd", {31'd0, rom_rd}, {31'd0, granted && inr});
            check_output("rom_addr", rom_addr, (granted && inr) ? gaddr : 32'd0);
            check_output("stall_cnt", {16'd0, stall_cnt}, m_stall);
            if (e0 && e1 && m_stall < 65535) m_stall = m_stall + 1;
            m_valid = granted;
            m_owner = gport;
            m_err   = !inr;
            m_addr  = gaddr;
            if (granted) m_last = gport;
        end

        case (lit_id)
            1: begin
                check_output("lit p0 grant rom_rd", {31'd0, rom_rd}, 32'd1);
                check_output("lit p0 grant rom_addr", rom_addr, 32'd3);
                check_output("lit p0 grant ack1", {31'd0, ack1}, 32'd0);
            end
            2: begin
                check_output("lit p0 ack0", {31'd0, ack0}, 32'd1);
                check_output("lit p0 data0", data0, 32'hDEAD_BEEF);
                check_output("lit p0 err0", {31'd0, err0}, 32'd0);
                check_output("lit p0 ack1", {31'd0, ack1}, 32'd0);
            end
            3: begin
                check_output("lit oor rom_rd", {31'd0, rom_rd}, 32'd0);
                check_output("lit oor rom_addr", rom_addr, 32'd0);
            end
            4: begin
                check_output("lit oor ack0", {31'd0, ack0}, 32'd1);
                check_output("lit oor err0", {31'd0, err0}, 32'd1);
                check_output("lit oor data0", data0, 32'd0);
                check_output("lit oor p1 rom_rd", {31'd0, rom_rd}, 32'd1);
                check_output("lit oor p1 rom_addr", rom_addr, 32'd5);
            end
            5: begin
                check_output("lit rst ack0", {31'd0, ack0}, 32'd0);
                check_output("lit rst data0", data0, 32'd0);
                check_output("lit rst err0", {31'd0, err0}, 32'd0);
                check_output("lit rst stall", {16'd0, stall_cnt}, 32'd0);
                check_output("lit rst rom_rd", {31'd0, rom_rd}, 32'd0);
            end
            6: check_output("lit stall sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
            7: begin
                check_output("lit p1 ack1 a", {31'd0, ack1}, 32'd1);
                check_output("lit p1 data1 a", data1, 32'h0BAD_F00D);
                check_output("lit p1 idle rom_rd", {31'd0, rom_rd}, 32'd0);
            end
            8: begin
                check_output("lit p1 ack1 b", {31'd0, ack1}, 32'd1);
                check_output("lit p1 data1 b", data1, 32'h7777_7777);
            end
            9: begin
                check_output("lit oor p1 ack1", {31'd0, ack1}, 32'd1);
                check_output("lit oor p1 data1", data1, 32'h5555_5555);
            end
            10: begin
                check_output("lit first tie rom_rd", {31'd0, rom_rd}, 32'd1);
                check_output("lit first tie rom_addr", rom_addr, 32'd1);
                check_output("lit first tie stall", {16'd0, stall_cnt}, 32'd0);
            end
            11: check_output("lit cont stall", {16'd0, stall_cnt}, 32'd1);
            default: ;
        endcase

        // Reaching saturation by real stalls would take ~131k cycles, so the
        // counter is parked just below the top during an idle cycle.
        if (preload_tag != preload_seen) begin
            preload_seen = preload_tag;
            force dut.stall_cnt_q = 16'hFFFC;
            m_stall = 32'h0000_FFFC;
            forced  = 1'b1;
        end else if (forced) begin
            release dut.stall_cnt_q;
            forced = 1'b0;
        end
    end

    task automatic apply_stimulus(input logic r0, input logic [31:0] a0,
                                  input logic r1, input logic [31:0] a1);
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
    endtask

    task automatic step(input int lit, input logic rst, input logic r0, input logic [31:0] a0,
                        input logic r1, input logic [31:0] a1);
        @(posedge clock);
        #1;
        reset  = rst;
        lit_id = lit;
        apply_stimulus(r0, a0, r1, a1);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        lit_id       = 0;
        preload_tag  = 0;
        preload_seen = 0;
        forced       = 1'b0;
        reset        = 1'b1;
        apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0);

        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Single port 0 read of ROM[3]
        step(1, 0, 1, 3, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Port 1 back-to-back reads of ROM[0] and ROM[7]
        step(0, 0, 0, 0, 1, 0);
        step(7, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 7);
        step(8, 0, 0, 0, 0, 0);

        // Out-of-range port 0 tie with an in-range port 1 request
        step(3, 0, 1, 8, 1, 5);
        step(4, 0, 0, 0, 1, 5);
        step(9, 0, 0, 0, 0, 0);

        // Reset in the ack cycle, then continuous requests from both ports
        step(0, 0, 1, 4, 0, 0);
        step(5, 1, 0, 0, 0, 0);
        step(5, 1, 1, 1, 1, 2);
        step(10, 0, 1, 1, 1, 2);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1, 2);
        step(11, 0, 1, 1, 1, 2);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Stall counter saturation through repeated ties
        step(0, 0, 0, 0, 0, 0);
        preload_tag = preload_tag + 1;
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 1, 1, 2);
            step(0, 0, 0, 0, 0, 0);
        end
        step(6, 0, 0, 0, 0, 0);
        step(0, 0, 1, 6, 1, 7);
        step(0, 0, 0, 0, 0, 0);
        step(6, 0, 0, 0, 0, 0);

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter sharing a single synchronous read-only memory (one-cycle read latency, registered output, read-enable gated) between an instruction-fetch requester (port 0) and a data-load requester (port 1). It issues at most one ROM read per cycle, returns each read to its owner with an acknowledge, flags out-of-range addresses without touching the ROM, and counts arbitration stalls. It sits between the core's fetch/load units and the coefficient/program ROM.

## Interface
- DWIDTH, 32, ROM data width.
- DEPTH_LOG2, 3, log2 of ROM depth; valid addresses are 0 .. 2**DEPTH_LOG2-1.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  read request from port 0 / port 1; held high until ack.
- addr0 / addr1  in  32  word address, stable while req high.
- ack0 / ack1  out  1  one-cycle pulse: read for this port completes this cycle.
- data0 / data1  out  DWIDTH  read data; valid only while ackN=1, else 0.
- err0 / err1  out  1  high with ackN when the address was out of range.
- rom_rd  out  1  ROM read enable (to ROM read-enable input).
- rom_addr  out  32  ROM address; 0 when rom_rd=0.
- rom_data  in  DWIDTH  ROM registered read data.
- stall_cnt  out  16  saturating count of cycles a request was eligible but not granted.

## Operation
- Eligibility: port N eligible in cycle C iff reqN=1 and ackN=0 in C (a port with a read in flight cannot be granted again).
- Arbitration: one grant per cycle. Only one eligible → it wins. Both eligible → round-robin: the port not granted most recently wins; last-grant pointer updates on every grant. After reset the pointer = 1, so port 0 wins the first tie.
- Grant with in-range address (addrN < 2**DEPTH_LOG2): rom_rd=1, rom_addr=addrN, combinationally in cycle C.
- Grant with out-of-range address: rom_rd=0, rom_addr=0; grant still consumes the slot and updates the pointer.
- In-flight register (registered at end of C): valid bit, owner port, error bit.
- Completion in C+1: ack of owner =1; data of owner = rom_data if error bit=0, else 0; err of owner = error bit. Other port's ack/data/err = 0.
- stall_cnt increments by 1 each cycle in which exactly one or both ports are eligible and at least one eligible port is not granted (i.e. both eligible: +1). Saturates at 16'hFFFF; cleared only by reset.
- No grant cycle: rom_rd=0, rom_addr=0.

## Timing
- Reset (asynchronous assert, immediate): ack0=ack1=0, data0=data1=0, err0=err1=0, in-flight valid=0, pointer=1, stall_cnt=0; rom_rd=0 and rom_addr=0 while reset is high. Deassertion takes effect on next rising edge.
- Reset mid-read: in-flight read discarded; no ack is ever produced for it; ROM output ignored.
- Read latency: grant cycle C → ack/data cycle C+1 (1 cycle).
- Per-port throughput: one read per 2 cycles (grant at C, ack at C+1, eligible again at C+2 if req still high; requester updates addr on the edge ending C+1).
- Aggregate throughput: one ROM read per cycle when both ports request continuously (alternating 0,1,0,1…).
- req dropped before grant: request abandoned, no ack. req dropped in the ack cycle: no effect on that completed read.
- Address changed while req high and not yet granted: the address present in the grant cycle is used.

## Test plan
- Single port 0 read, addr0=3, ROM[3]=0xDEADBEEF: rom_rd=1, rom_addr=3 in cycle C; ack0=1, data0=0xDEADBEEF, err0=0 in C+1; ack1 stays 0.
- Both ports request continuously from reset, addr0=1, addr1=2: grants 0,1,0,1…; ack0 and ack1 alternate every cycle; rom_rd=1 every cycle; stall_cnt increments 1 on the first cycle only then holds (one port always in flight).
- Port 1 alone, back-to-back addr1=0 then 7: grants on C and C+2, acks on C+1 and C+3 with ROM[0], ROM[7]; rom_rd=0 on C+1.
- Out-of-range addr0=8 (DEPTH_LOG2=3): rom_rd=0, rom_addr=0 in C; ack0=1, err0=1, data0=0 in C+1; concurrent in-range port 1 request is granted C+1.
- Assert reset in the cycle after a grant: ack/data/err forced 0 immediately, no ack after release; stall_cnt=0; first tie after release goes to port 0.
- Force stall_cnt near saturation (hold both requests with port 1 never re-eligible scenario via long tie run): counter reaches 16'hFFFF and stays there.
